cordic_pipe: RTL and testbench
==============================

// Module: cordic_pipe
// PURPOSE
//  Parametrised, fully pipelined rotation-mode CORDIC that yields cos and sin of a fixed-point angle.
//  One stage per register, with a valid/ready handshake and global stall.
//  Sits between the float->fixed unpacker and the packer in the trig datapath.
//  Accepts one angle per clock and carries a user tag alongside each sample.
// PARAMETERS
//  W       32  datapath width. Angle and results are signed Q3.(W-3).
//  STAGES  24  number of CORDIC iterations, which is also the number of pipeline stages (2..W-1).
//  TAG_W   4   width of the sideband tag passed through unchanged.
// PORTS
//  clk        in   1      clock; all logic on its rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      in_angle/in_tag are valid
//  in_ready   out  1      stage 0 can accept this cycle
//  in_angle   in   W      signed Q3.(W-3) radians
//  in_tag     in   TAG_W  sideband, returned with the result
//  out_valid  out  1      out_cos/out_sin/out_tag are valid
//  out_ready  in   1      downstream accepts this cycle
//  out_cos    out  W      signed Q3.(W-3) cos(angle)
//  out_sin    out  W      signed Q3.(W-3) sin(angle)
//  out_tag    out  TAG_W  tag of the same sample
// BEHAVIOUR
//  - Reset (asynchronous): every stage valid bit=0 and every x/y/z/tag register=0, so all outputs read 0.
//    Reset taken mid-flight discards all samples; after release the first accept is clean.
//  - Handshake:
//    - advance = !out_valid || out_ready; in_ready = advance (combinational, no dependence on in_valid).
//    - On advance, every stage register loads from its predecessor, valid bits included.
//    - When advance=0, all stages hold; outputs stay stable while out_valid && !out_ready.
//    - Input accepted iff in_valid && in_ready; output consumed iff out_valid && out_ready.
//  - Latency: exactly STAGES advancing cycles from accept to out_valid. Throughput is 1 per cycle
//    with out_ready held high. Bubbles propagate as valid=0 and are never compacted.
//  - Stage 0 seed: x=K (CORDIC gain 0.60725... in Q3.(W-3)), y=0, z=angle after the pre-rotation below.
//  - Stage i (i=0..STAGES-1): d = (z>=0) ? +1 : -1
//      x' = x - d*(y>>>i), y' = y + d*(x>>>i), z' = z - d*ATAN[i]
//    - >>> is an arithmetic shift. Wrap is two's complement with no saturation and no rounding (truncate).
//    - ATAN[i] = round(atan(2^-i)*2^(W-3)).
//  - Convergence is valid for |angle| <= 1.7433 rad. Outside that range the output is unspecified
//    unless the optional feature is compiled in.
//  - out_cos = final x; out_sin = final y. The final z residual is not exported.
//  - Simultaneous accept and consume in one cycle is legal and keeps full throughput.
// CONFIGURATION
//  CORDIC_QUADRANT_EN defined:
//    - Pre-rotation: if angle > PI/2 then z0 = angle - PI; if angle < -PI/2 then z0 = angle + PI.
//    - A flip bit travels with the sample. When set, out_cos and out_sin are both negated
//      (two's complement) at the output register.
//    - Valid range becomes [-PI, PI]. The extra stage is not added, so latency is unchanged:
//      the pre-rotation is combinational in stage 0.
//  CORDIC_QUADRANT_EN undefined: no pre-rotation, no flip bit, and the range is limited as stated above.
// STRUCTURE
//  - Package cordic_pkg holds:
//    - typedef fix_t (signed [W-1:0])
//    - localparams FRAC=W-3, PI_FIX, HALF_PI_FIX, K_FIX
//    - function atan_fix(i) built as a constant table up to index 31
//    - typedef struct stage_t {x, y, z, tag, valid}
//  - Sub-module cordic_stage(i): one registered micro-rotation with hold/advance enable.
//    It is instantiated STAGES times in a generate loop.
//  - No $readmemh: the arctangent table is elaboration-time constant.
// TESTING
//  Tolerance: +-128 LSB against a real-valued model at W=32, STAGES=24.
//  1. angle=0, tag=3, out_ready=1
//     -> after 24 cycles out_valid=1, cos~0x2000_0000, sin~0, tag=3.
//  2. angle=PI/3 then -PI/4 back to back
//     -> two consecutive outputs (0.5, 0.8660) then (0.7071, -0.7071), in order.
//  3. Stream 100 random angles, out_ready toggled randomly
//     -> no loss or duplication, tags in order, outputs stable while stalled.
//  4. rst_n pulsed low with 10 samples in flight
//     -> out_valid=0 and outputs 0 immediately; no stale output after release.
//  5. CORDIC_QUADRANT_EN, angle=3PI/4 -> cos~-0.7071, sin~0.7071;
//     angle=-PI -> cos~-1.0, sin~0.
//  6. out_ready=0 with pipeline full
//     -> in_ready=0, in_valid ignored; release out_ready -> 1 result/cycle resumes.

Source files
------------

// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - Shared types, constants and elaboration-time tables for the CORDIC pipeline
package cordic_pkg;

    localparam int  CORDIC_W     = 32;
    localparam int  CORDIC_TAG_W = 4;
    localparam int  FRAC         = CORDIC_W - 3;
    localparam real PI_REAL      = 3.14159265358979323846;

    typedef logic signed [CORDIC_W-1:0] fix_t;

    typedef struct packed {
        fix_t                    x;
        fix_t                    y;
        fix_t                    z;
        logic [CORDIC_TAG_W-1:0] tag;
        logic                    valid;
    } stage_t;

    // atan(2^-i); past i=15 the cubic term alone is exact to double precision
    function automatic real atan_real(input int i);
        real t;
        case (i)
            0:  return 0.78539816339744830962;
            1:  return 0.46364760900080611621;
            2:  return 0.24497866312686415417;
            3:  return 0.12435499454676143503;
            4:  return 0.06241880999595734847;
            5:  return 0.03123983343026827625;
            6:  return 0.01562372862047683080;
            7:  return 0.00781234106010111130;
            8:  return 0.00390623013196697182;
            9:  return 0.00195312251647881868;
            10: return 0.00097656218955931943;
            11: return 0.00048828121119489829;
            12: return 0.00024414062014936177;
            13: return 0.00012207031189367021;
            14: return 0.00006103515617420877;
            15: return 0.00003051757811552610;
            default: begin
                if (i > 31) begin
                    return 0.0;
                end
                t = 2.0 ** (-i);
                return t - (t * t * t) / 3.0;
            end
        endcase
    endfunction

    function automatic longint to_fix(input real v, input int frac);
        return longint'(v * (2.0 ** frac));
    endfunction

    function automatic longint atan_fix(input int i, input int frac);
        return to_fix(atan_real(i), frac);
    endfunction

    // Product of 1/sqrt(1+2^-2i); square root by Newton iteration
    function automatic real gain_real(input int stages);
        real p;
        real s;
        p = 1.0;
        for (int i = 0; i < stages; i++) begin
            p = p / (1.0 + 2.0 ** (-2 * i));
        end
        s = p;
        for (int n = 0; n < 40; n++) begin
            s = 0.5 * (s + p / s);
        end
        return s;
    endfunction

    localparam fix_t PI_FIX      = fix_t'(to_fix(PI_REAL, FRAC));
    localparam fix_t HALF_PI_FIX = fix_t'(to_fix(PI_REAL / 2.0, FRAC));
    localparam fix_t K_FIX       = fix_t'(to_fix(gain_real(24), FRAC));

endpackage

// File: rtl/cordic_stage.sv
// rtl/cordic_stage.sv - One registered CORDIC micro-rotation with global advance enable
module cordic_stage
    import cordic_pkg::*;
#(
    parameter int                 W       = 32,
    parameter int                 TAG_W   = 4,
    parameter int                 SHIFT   = 0,
    parameter logic signed [W-1:0] ATAN   = '0,
    parameter bit                 NEG_OUT = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                advance,
    input  logic signed [W-1:0] src_x,
    input  logic signed [W-1:0] src_y,
    input  logic signed [W-1:0] src_z,
    input  logic [TAG_W-1:0]    src_tag,
    input  logic                src_valid,
    input  logic                src_flip,
    output logic signed [W-1:0] x,
    output logic signed [W-1:0] y,
    output logic signed [W-1:0] z,
    output logic [TAG_W-1:0]    tag,
    output logic                valid,
    output logic                flip
);

    logic signed [W-1:0] x_sh;
    logic signed [W-1:0] y_sh;
    logic signed [W-1:0] x_rot;
    logic signed [W-1:0] y_rot;
    logic signed [W-1:0] x_n;
    logic signed [W-1:0] y_n;
    logic signed [W-1:0] z_n;

    always_comb begin
        x_sh = src_x >>> SHIFT;
        y_sh = src_y >>> SHIFT;
        if (src_z[W-1]) begin
            x_rot = src_x + y_sh;
            y_rot = src_y - x_sh;
            z_n   = src_z + ATAN;
        end else begin
            x_rot = src_x - y_sh;
            y_rot = src_y + x_sh;
            z_n   = src_z - ATAN;
        end
        // Final stage folds the quadrant flip into its own register
        if (NEG_OUT && src_flip) begin
            x_n = -x_rot;
            y_n = -y_rot;
        end else begin
            x_n = x_rot;
            y_n = y_rot;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x     <= '0;
            y     <= '0;
            z     <= '0;
            tag   <= '0;
            valid <= 1'b0;
            flip  <= 1'b0;
        end else if (advance) begin
            x     <= x_n;
            y     <= y_n;
            z     <= z_n;
            tag   <= src_tag;
            valid <= src_valid;
            flip  <= src_flip;
        end
    end

endmodule

// File: rtl/cordic_pipe.sv
// rtl/cordic_pipe.sv - Pipelined rotation-mode CORDIC (cos/sin); CORDIC_QUADRANT_EN adds +-PI pre-rotation
module cordic_pipe
    import cordic_pkg::*;
#(
    parameter int W      = 32,
    parameter int STAGES = 24,
    parameter int TAG_W  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] in_angle,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] out_cos,
    output logic signed [W-1:0] out_sin,
    output logic [TAG_W-1:0]    out_tag
);

    localparam int FRAC_B = W - 3;
    localparam logic signed [W-1:0] K_SEED = W'(to_fix(gain_real(STAGES), FRAC_B));
`ifdef CORDIC_QUADRANT_EN
    localparam logic signed [W-1:0] PI_B      = W'(to_fix(PI_REAL, FRAC_B));
    localparam logic signed [W-1:0] HALF_PI_B = W'(to_fix(PI_REAL / 2.0, FRAC_B));
`endif

    logic signed [W-1:0] x_pipe     [0:STAGES];
    logic signed [W-1:0] y_pipe     [0:STAGES];
    logic signed [W-1:0] z_pipe     [0:STAGES];
    logic [TAG_W-1:0]    tag_pipe   [0:STAGES];
    logic                valid_pipe [0:STAGES];
    logic                flip_pipe  [0:STAGES];

    logic                advance;
    logic signed [W-1:0] seed_z;
    logic                seed_flip;
    logic [W:0]          tail_unused;

    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;

    always_comb begin
`ifdef CORDIC_QUADRANT_EN
        // Fold the outer half-planes onto [-PI/2, PI/2]; the flip restores the sign at the end
        if (in_angle > HALF_PI_B) begin
            seed_z    = in_angle - PI_B;
            seed_flip = 1'b1;
        end else if (in_angle < -HALF_PI_B) begin
            seed_z    = in_angle + PI_B;
            seed_flip = 1'b1;
        end else begin
            seed_z    = in_angle;
            seed_flip = 1'b0;
        end
`else
        seed_z    = in_angle;
        seed_flip = 1'b0;
`endif
    end

    assign x_pipe[0]     = K_SEED;
    assign y_pipe[0]     = '0;
    assign z_pipe[0]     = seed_z;
    assign tag_pipe[0]   = in_tag;
    assign valid_pipe[0] = in_valid;
    assign flip_pipe[0]  = seed_flip;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        cordic_stage #(
            .W       (W),
            .TAG_W   (TAG_W),
            .SHIFT   (i),
            .ATAN    (W'(atan_fix(i, FRAC_B))),
            .NEG_OUT (i == STAGES - 1)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .advance   (advance),
            .src_x     (x_pipe[i]),
            .src_y     (y_pipe[i]),
            .src_z     (z_pipe[i]),
            .src_tag   (tag_pipe[i]),
            .src_valid (valid_pipe[i]),
            .src_flip  (flip_pipe[i]),
            .x         (x_pipe[i+1]),
            .y         (y_pipe[i+1]),
            .z         (z_pipe[i+1]),
            .tag       (tag_pipe[i+1]),
            .valid     (valid_pipe[i+1]),
            .flip      (flip_pipe[i+1])
        );
    end

    // Residual angle and spent flip bit of the last stage are not exported
    assign tail_unused = {z_pipe[STAGES], flip_pipe[STAGES]};

    assign out_valid = valid_pipe[STAGES];
    assign out_cos   = x_pipe[STAGES];
    assign out_sin   = y_pipe[STAGES];
    assign out_tag   = tag_pipe[STAGES];

endmodule

// File: tb/tb_cordic_pipe.sv
// tb/tb_cordic_pipe.sv - Scoreboard bench for cordic_pipe at W=32, STAGES=24
module tb_cordic_pipe;

    localparam int     W      = 32;
    localparam int     STAGES = 24;
    localparam int     TAG_W  = 4;
    localparam real    SCALE  = 536870912.0;
    localparam longint TOL    = 128;
`ifdef CORDIC_QUADRANT_EN
    localparam longint ANG_LIM = 1686000000;
`else
    localparam longint ANG_LIM = 930000000;
`endif

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic signed [W-1:0] in_angle = '0;
    logic [TAG_W-1:0]    in_tag = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic signed [W-1:0] out_cos;
    logic signed [W-1:0] out_sin;
    logic [TAG_W-1:0]    out_tag;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [TAG_W-1:0] tag;
        longint           c;
        longint           s;
    } exp_t;
    exp_t sb[$];

    cordic_pipe #(.W(W), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_angle  (in_angle),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_cos   (out_cos),
        .out_sin   (out_sin),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint got, input longint exp, input longint tol = 0);
        n_checks++;
        if (got > exp + tol || got < exp - tol) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (tol %0d) at %0t", name, got, exp, tol, $time);
        end
    endtask

    function automatic void expect_sample(input logic signed [W-1:0] a, input logic [TAG_W-1:0] t);
        exp_t e;
        real  ang;
        ang   = $itor(a) / SCALE;
        e.tag = t;
        e.c   = longint'($cos(ang) * SCALE);
        e.s   = longint'($sin(ang) * SCALE);
        sb.push_back(e);
    endfunction

    function automatic logic signed [W-1:0] fix_of(input real v);
        return W'(longint'(v * SCALE));
    endfunction

    function automatic logic signed [W-1:0] rand_angle();
        longint r;
        r = longint'($urandom_range(32'(2 * ANG_LIM), 0)) - ANG_LIM;
        return W'(r);
    endfunction

    task automatic step(input logic v, input logic signed [W-1:0] a, input logic [TAG_W-1:0] t,
                        input logic ordy, output logic acc);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_angle  = a;
        in_tag    = t;
        out_ready = ordy;
        @(negedge clk);
        acc = in_valid && in_ready;
        if (acc) expect_sample(a, t);
    endtask

    task automatic drain();
        logic acc;
        for (int k = 0; k < 200 && sb.size() != 0; k++) step(1'b0, '0, '0, 1'b1, acc);
        check("drain_empty", sb.size(), 0);
    endtask

    // Output monitor: scoreboard pop on consume, stability while stalled
    logic                prev_stall = 1'b0;
    logic signed [W-1:0] prev_cos = '0;
    logic signed [W-1:0] prev_sin = '0;
    logic [TAG_W-1:0]    prev_tag = '0;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_cos", out_cos, prev_cos);
                check("stall_sin", out_sin, prev_sin);
                check("stall_tag", out_tag, prev_tag);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_out", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("out_tag", out_tag, e.tag);
                    check("out_cos", out_cos, e.c, TOL);
                    check("out_sin", out_sin, e.s, TOL);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_cos   = out_cos;
            prev_sin   = out_sin;
            prev_tag   = out_tag;
        end
    end

    initial begin : stim
        logic acc;
        int   lat;
        int   cnt;

        #1;
        check("rst_valid", out_valid, 0);
        check("rst_cos", out_cos, 0);
        check("rst_sin", out_sin, 0);
        check("rst_tag", out_tag, 0);
        check("rst_in_ready", in_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 1: angle 0, latency of exactly STAGES cycles
        step(1'b1, '0, 4'd3, 1'b1, acc);
        check("t1_accept", acc, 1);
        lat = -1;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            step(1'b0, '0, '0, 1'b1, acc);
            if (out_valid) lat = k;
        end
        check("t1_latency", lat, STAGES);
        drain();

        // 2: back-to-back PI/3 then -PI/4
        step(1'b1, fix_of(1.0471975511965976), 4'd5, 1'b1, acc);
        step(1'b1, fix_of(-0.7853981633974483), 4'd6, 1'b1, acc);
        check("t2_queued", sb.size(), 2);
        drain();

        // 3: random stream with random backpressure
        cnt = 0;
        for (int cyc = 0; cyc < 3000 && cnt < 100; cyc++) begin
            step($urandom_range(3, 0) != 0, rand_angle(), cnt[TAG_W-1:0], $urandom_range(1, 0) == 1, acc);
            if (acc) cnt++;
        end
        check("t3_accepted", cnt, 100);
        drain();

        // 4: asynchronous reset with 10 samples in flight
        for (int k = 0; k < 10; k++) step(1'b1, rand_angle(), k[TAG_W-1:0], 1'b1, acc);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("t4_valid", out_valid, 0);
        check("t4_cos", out_cos, 0);
        check("t4_sin", out_sin, 0);
        check("t4_tag", out_tag, 0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            step(1'b0, '0, '0, 1'b1, acc);
            if (out_valid) cnt++;
        end
        check("t4_no_stale", cnt, 0);
        step(1'b1, fix_of(0.5), 4'd9, 1'b1, acc);
        drain();

`ifdef CORDIC_QUADRANT_EN
        // 5: outer quadrants
        step(1'b1, fix_of(2.356194490192345), 4'd10, 1'b1, acc);
        step(1'b1, fix_of(-3.141592653589793), 4'd11, 1'b1, acc);
        step(1'b1, fix_of(-2.0), 4'd12, 1'b1, acc);
        drain();
`endif

        // 6: full pipeline under backpressure, then full-rate drain
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            step(1'b1, rand_angle(), k[TAG_W-1:0], 1'b0, acc);
            if (acc) cnt++;
        end
        check("t6_fill_count", cnt, STAGES);
        check("t6_in_ready", in_ready, 0);
        check("t6_out_valid", out_valid, 1);
        for (int k = 0; k < STAGES; k++) begin
            step(1'b0, '0, '0, 1'b1, acc);
            check("t6_resume", out_valid, 1);
        end
        step(1'b0, '0, '0, 1'b1, acc);
        check("t6_empty", out_valid, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
